// File: rtl/sub_pipe_pkg.sv
// Shared definitions for the pipelined parametrised subtractor:
// result mode encodings and the stage-count helper.
package sub_pipe_pkg;

   typedef enum logic [1:0] {
      MODE_WRAP = 2'b00,
      MODE_USAT = 2'b01,
      MODE_SSAT = 2'b10
   } mode_e;

   function automatic int stages_f(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/sub_chunk.sv
// Combinational CHUNK-bit ripple-borrow subtractor slice. It also exposes the
// borrow entering its top bit, so the overflow can be derived from it.
module sub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             bin,
   output logic [CHUNK-1:0] d,
   output logic             bout,
   output logic             msb_bin
);

   // per-bit full-subtractor chain; msb_bin ends up as the borrow into the top bit
   always_comb begin
      logic bw_s;
      bw_s    = bin;
      msb_bin = 1'b0;
      d       = {CHUNK{1'b0}};
      for (int i = 0; i < CHUNK; i++) begin
         msb_bin = bw_s;
         d[i]    = a[i] ^ b[i] ^ bw_s;
         bw_s    = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw_s);
      end
      bout = bw_s;
   end

endmodule

// File: rtl/sub_pipe_param.sv
// Pipelined D = A - B - b_in, one CHUNK-bit slice per stage, with valid/ready
// back-pressure and wrap / unsigned-saturate / signed-saturate output modes.
module sub_pipe_param
   import sub_pipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             b_out,
   output logic             ovf
);

   localparam int               STAGES  = stages_f(WIDTH, CHUNK);
   localparam logic [WIDTH-1:0] CH_MASK = WIDTH'({CHUNK{1'b1}});
   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   // bank k holds the beat about to be resolved by stage k
   logic             vld_r  [STAGES];
   logic [WIDTH-1:0] a_r    [STAGES];
   logic [WIDTH-1:0] b_r    [STAGES];
   logic [WIDTH-1:0] dp_r   [STAGES];
   logic             bor_r  [STAGES];
   logic [1:0]       mode_r [STAGES];

   logic [CHUNK-1:0] dch_s  [STAGES];
   logic             bout_s [STAGES];
   logic             msbb_s [STAGES];
   logic [WIDTH-1:0] dnxt_s [STAGES];
   logic             adv_s;
   logic             ovf_s;
   logic [WIDTH-1:0] dsat_s;

   assign adv_s    = !out_valid || out_ready;
   assign in_ready = adv_s;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      sub_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a       (a_r[k][k*CHUNK +: CHUNK]),
         .b       (b_r[k][k*CHUNK +: CHUNK]),
         .bin     (bor_r[k]),
         .d       (dch_s[k]),
         .bout    (bout_s[k]),
         .msb_bin (msbb_s[k])
      );
      assign dnxt_s[k] = (dp_r[k] & ~(CH_MASK << (k*CHUNK))) | (WIDTH'(dch_s[k]) << (k*CHUNK));
   end

   assign ovf_s = msbb_s[STAGES-1] ^ bout_s[STAGES-1];

   // output saturation applied to the fully resolved raw difference
   always_comb begin
      dsat_s = dnxt_s[STAGES-1];
      case (mode_r[STAGES-1])
         MODE_USAT: begin
            if (bout_s[STAGES-1]) dsat_s = {WIDTH{1'b0}};
            else                  dsat_s = dnxt_s[STAGES-1];
         end
         MODE_SSAT: begin
            if (ovf_s) dsat_s = a_r[STAGES-1][WIDTH-1] ? SAT_NEG : SAT_POS;
            else       dsat_s = dnxt_s[STAGES-1];
         end
         default: dsat_s = dnxt_s[STAGES-1];
      endcase
   end

   // pipeline shift on advance; everything holds while the output is stalled
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            vld_r[k]  <= 1'b0;
            a_r[k]    <= {WIDTH{1'b0}};
            b_r[k]    <= {WIDTH{1'b0}};
            dp_r[k]   <= {WIDTH{1'b0}};
            bor_r[k]  <= 1'b0;
            mode_r[k] <= 2'b00;
         end
         out_valid <= 1'b0;
         d         <= {WIDTH{1'b0}};
         b_out     <= 1'b0;
         ovf       <= 1'b0;
      end else if (adv_s) begin
         vld_r[0]  <= in_valid;
         a_r[0]    <= a;
         b_r[0]    <= b;
         dp_r[0]   <= {WIDTH{1'b0}};
         bor_r[0]  <= b_in;
         mode_r[0] <= mode;
         for (int k = 1; k < STAGES; k++) begin
            vld_r[k]  <= vld_r[k-1];
            a_r[k]    <= a_r[k-1];
            b_r[k]    <= b_r[k-1];
            dp_r[k]   <= dnxt_s[k-1];
            bor_r[k]  <= bout_s[k-1];
            mode_r[k] <= mode_r[k-1];
         end
         out_valid <= vld_r[STAGES-1];
         // bubbles leave the last result on d
         if (vld_r[STAGES-1]) begin
            d     <= dsat_s;
            b_out <= bout_s[STAGES-1];
            ovf   <= ovf_s;
         end
      end
   end

endmodule

// File: tb/tb_sub_pipe_param.sv
// Directed and streaming checks of sub_pipe_param, plus a width/chunk sweep
// over three extra instances.
module tb_sub_pipe_param;

   typedef struct packed {
      logic [31:0] d;
      logic        bo;
      logic        ov;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, b_in, out_valid, out_ready, b_out, ovf;
   logic [31:0] a, b, d;
   logic [1:0]  mode;
   int          checks = 0;
   int          errors = 0;

   logic        sw_valid, sw_bin;
   logic [63:0] sw_a, sw_b;
   logic        ir_a, ov_a, bo_a, of_a, ir_b, ov_b, bo_b, of_b, ir_c, ov_c, bo_c, of_c;
   logic [15:0] d_a, d_b;
   logic [63:0] d_c;

   always #5 clk = ~clk;

   sub_pipe_param #(.WIDTH(32), .CHUNK(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .b_in(b_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
      .d(d), .b_out(b_out), .ovf(ovf));

   sub_pipe_param #(.WIDTH(16), .CHUNK(4)) u_16_4 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir_a), .a(sw_a[15:0]), .b(sw_b[15:0]),
      .b_in(sw_bin), .mode(2'b00), .out_valid(ov_a), .out_ready(1'b1),
      .d(d_a), .b_out(bo_a), .ovf(of_a));

   sub_pipe_param #(.WIDTH(16), .CHUNK(16)) u_16_16 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir_b), .a(sw_a[15:0]), .b(sw_b[15:0]),
      .b_in(sw_bin), .mode(2'b00), .out_valid(ov_b), .out_ready(1'b1),
      .d(d_b), .b_out(bo_b), .ovf(of_b));

   sub_pipe_param #(.WIDTH(64), .CHUNK(8)) u_64_8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(ir_c), .a(sw_a), .b(sw_b),
      .b_in(sw_bin), .mode(2'b00), .out_valid(ov_c), .out_ready(1'b1),
      .d(d_c), .b_out(bo_c), .ovf(of_c));

   function automatic res_t model(input logic [31:0] ta, input logic [31:0] tb,
                                  input logic tbin, input logic [1:0] tm);
      res_t        r;
      logic [32:0] full;
      logic [31:0] raw;
      full = {1'b0, ta} - {1'b0, tb} - {32'd0, tbin};
      raw  = full[31:0];
      r.bo = full[32];
      r.ov = (ta[31] != tb[31]) && (raw[31] != ta[31]);
      case (tm)
         2'd1:    r.d = r.bo ? 32'd0 : raw;
         2'd2:    r.d = r.ov ? (ta[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : raw;
         default: r.d = raw;
      endcase
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drive one beat with out_ready high; report latency (edges after acceptance) and result
   task automatic run_beat(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                           input logic [1:0] tm, output int lat, output res_t r);
      in_valid = 1'b1; a = ta; b = tb; b_in = tbin; mode = tm; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 12) begin
         step();
         lat++;
      end
      r = '{d: d, bo: b_out, ov: ovf};
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 32'd0; b = 32'd0; b_in = 1'b0; mode = 2'd0;
      sw_valid = 1'b0; sw_a = 64'd0; sw_b = 64'd0; sw_bin = 1'b0;
      step(); step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if ({d, b_out, ovf} !== 34'd0) begin errors++; $display("FAIL reset_outputs got d=%h bo=%b ov=%b exp 0", d, b_out, ovf); end
      rst = 1'b0;
      step();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_basic();
      int   lat;
      res_t r;
      run_beat(32'h0001_0000, 32'h0000_0001, 1'b0, 2'd0, lat, r);
      checks++; if (lat !== 4) begin errors++; $display("FAIL basic_latency got %0d exp 4", lat); end
      checks++; if (r !== '{d: 32'h0000_FFFF, bo: 1'b0, ov: 1'b0}) begin errors++; $display("FAIL basic_result got %h/%b/%b exp 0000ffff/0/0", r.d, r.bo, r.ov); end
   endtask

   task automatic test_underflow();
      int   lat;
      res_t r;
      run_beat(32'd0, 32'd1, 1'b0, 2'd0, lat, r);
      checks++; if (r !== '{d: 32'hFFFF_FFFF, bo: 1'b1, ov: 1'b0}) begin errors++; $display("FAIL uflow_wrap got %h/%b/%b exp ffffffff/1/0", r.d, r.bo, r.ov); end
      run_beat(32'd0, 32'd1, 1'b0, 2'd1, lat, r);
      checks++; if (r !== '{d: 32'h0000_0000, bo: 1'b1, ov: 1'b0}) begin errors++; $display("FAIL uflow_usat got %h/%b/%b exp 00000000/1/0", r.d, r.bo, r.ov); end
      run_beat(32'd0, 32'd1, 1'b0, 2'd3, lat, r);
      checks++; if (r !== '{d: 32'hFFFF_FFFF, bo: 1'b1, ov: 1'b0}) begin errors++; $display("FAIL uflow_mode3 got %h/%b/%b exp ffffffff/1/0", r.d, r.bo, r.ov); end
      run_beat(32'h1234_5678, 32'h1234_5678, 1'b1, 2'd0, lat, r);
      checks++; if (r !== '{d: 32'hFFFF_FFFF, bo: 1'b1, ov: 1'b0}) begin errors++; $display("FAIL equal_bin got %h/%b/%b exp ffffffff/1/0", r.d, r.bo, r.ov); end
   endtask

   task automatic test_ssat();
      int   lat;
      res_t r;
      run_beat(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'd2, lat, r);
      checks++; if (r !== '{d: 32'h7FFF_FFFF, bo: 1'b1, ov: 1'b1}) begin errors++; $display("FAIL ssat_pos got %h/%b/%b exp 7fffffff/1/1", r.d, r.bo, r.ov); end
      run_beat(32'h8000_0000, 32'h0000_0001, 1'b0, 2'd2, lat, r);
      checks++; if (r !== '{d: 32'h8000_0000, bo: 1'b0, ov: 1'b1}) begin errors++; $display("FAIL ssat_neg got %h/%b/%b exp 80000000/0/1", r.d, r.bo, r.ov); end
      run_beat(32'h8000_0000, 32'h0000_0001, 1'b0, 2'd0, lat, r);
      checks++; if (r !== '{d: 32'h7FFF_FFFF, bo: 1'b0, ov: 1'b1}) begin errors++; $display("FAIL ovf_wrap got %h/%b/%b exp 7fffffff/0/1", r.d, r.bo, r.ov); end
      run_beat(32'd5, 32'd3, 1'b0, 2'd2, lat, r);
      checks++; if (r !== '{d: 32'h0000_0002, bo: 1'b0, ov: 1'b0}) begin errors++; $display("FAIL ssat_noovf got %h/%b/%b exp 00000002/0/0", r.d, r.bo, r.ov); end
   endtask

   task automatic test_back_to_back();
      res_t q[$];
      res_t exp_r, held;
      logic held_v = 1'b0;
      logic acc, cons;
      int   sent = 0, got = 0, cyc = 0, extra = 0;
      in_valid = 1'b1; a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1)); mode = 2'($urandom_range(0, 3));
      while (got < 20 && cyc < 400) begin
         out_ready = 1'($urandom_range(0, 1));
         #1;
         checks++; if (in_ready !== !(out_valid && !out_ready)) begin errors++; $display("FAIL stream_in_ready got %b ov=%b or=%b", in_ready, out_valid, out_ready); end
         if (held_v) begin
            checks++;
            if ({out_valid, d, b_out, ovf} !== {1'b1, held}) begin errors++; $display("FAIL stream_stable got %b/%h/%b/%b exp 1/%h/%b/%b", out_valid, d, b_out, ovf, held.d, held.bo, held.ov); end
         end
         held_v = out_valid && !out_ready;
         held   = '{d: d, bo: b_out, ov: ovf};
         acc    = in_valid && in_ready;
         cons   = out_valid && out_ready;
         if (acc) begin
            q.push_back(model(a, b, b_in, mode));
            sent++;
         end
         if (cons) begin
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL stream_dup got extra beat %h exp none", d); end
            else begin
               exp_r = q.pop_front();
               if ({d, b_out, ovf} !== exp_r) begin errors++; $display("FAIL stream_data got %h/%b/%b exp %h/%b/%b", d, b_out, ovf, exp_r.d, exp_r.bo, exp_r.ov); end
            end
            got++;
         end
         step();
         cyc++;
         if (acc) begin
            if (sent < 20) begin
               a = $urandom; b = $urandom; b_in = 1'($urandom_range(0, 1)); mode = 2'($urandom_range(0, 3));
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      checks++; if (got !== 20) begin errors++; $display("FAIL stream_count got %0d exp 20", got); end
      checks++; if (q.size() !== 0) begin errors++; $display("FAIL stream_leftover got %0d exp 0", q.size()); end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         if (out_valid) extra++;
      end
      checks++; if (extra !== 0) begin errors++; $display("FAIL stream_extra got %0d exp 0", extra); end
   endtask

   task automatic test_reset_mid();
      int   lat;
      int   stale = 0;
      res_t r;
      run_beat(32'd5, 32'd3, 1'b0, 2'd0, lat, r);
      out_ready = 1'b1; mode = 2'd0; b_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; a = 32'd100 + 32'(i); b = 32'd1;
         step();
      end
      in_valid = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
      checks++; if (d !== 32'd0) begin errors++; $display("FAIL midrst_d got %h exp 0", d); end
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) stale++;
      end
      checks++; if (stale !== 0) begin errors++; $display("FAIL midrst_stale got %0d exp 0", stale); end
      run_beat(32'h0000_0010, 32'h0000_0020, 1'b1, 2'd0, lat, r);
      checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got %0d exp 4", lat); end
      checks++; if (r !== '{d: 32'hFFFF_FFEF, bo: 1'b1, ov: 1'b0}) begin errors++; $display("FAIL midrst_result got %h/%b/%b exp ffffffef/1/0", r.d, r.bo, r.ov); end
   endtask

   task automatic test_sweep();
      logic [17:0] qa[$], qb[$];
      logic [65:0] qc[$];
      logic [16:0] t16;
      logic [64:0] t64;
      logic [17:0] e16;
      logic [65:0] e64;
      int lat_a = 0, lat_b = 0, lat_c = 0;
      // a == b with borrow-in: every width must give all ones and a borrow
      sw_a = 64'h0123_4567_89AB_CDEF; sw_b = sw_a; sw_bin = 1'b1; sw_valid = 1'b1;
      step();
      sw_valid = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (ov_a && lat_a == 0) begin
            lat_a = c; checks++;
            if ({d_a, bo_a} !== {16'hFFFF, 1'b1}) begin errors++; $display("FAIL sweep16_4_eq got %h/%b exp ffff/1", d_a, bo_a); end
         end
         if (ov_b && lat_b == 0) begin
            lat_b = c; checks++;
            if ({d_b, bo_b} !== {16'hFFFF, 1'b1}) begin errors++; $display("FAIL sweep16_16_eq got %h/%b exp ffff/1", d_b, bo_b); end
         end
         if (ov_c && lat_c == 0) begin
            lat_c = c; checks++;
            if ({d_c, bo_c} !== {64'hFFFF_FFFF_FFFF_FFFF, 1'b1}) begin errors++; $display("FAIL sweep64_8_eq got %h/%b exp all-ones/1", d_c, bo_c); end
         end
      end
      checks++; if ({lat_a, lat_b, lat_c} !== {32'd4, 32'd1, 32'd8}) begin errors++; $display("FAIL sweep_latency got %0d/%0d/%0d exp 4/1/8", lat_a, lat_b, lat_c); end
      checks++; if ({ir_a, ir_b, ir_c} !== 3'b111) begin errors++; $display("FAIL sweep_in_ready got %b exp 111", {ir_a, ir_b, ir_c}); end
      for (int c = 0; c < 40; c++) begin
         if (c < 30) begin
            sw_valid = 1'b1;
            if (c == 0) begin
               sw_a = 64'd0; sw_b = 64'hFFFF_FFFF_FFFF_FFFF; sw_bin = 1'b1;
            end else begin
               sw_a = {$urandom, $urandom}; sw_b = {$urandom, $urandom}; sw_bin = 1'($urandom_range(0, 1));
            end
            t16 = {1'b0, sw_a[15:0]} - {1'b0, sw_b[15:0]} - {16'd0, sw_bin};
            e16 = {(sw_a[15] != sw_b[15]) && (t16[15] != sw_a[15]), t16};
            t64 = {1'b0, sw_a} - {1'b0, sw_b} - {64'd0, sw_bin};
            e64 = {(sw_a[63] != sw_b[63]) && (t64[63] != sw_a[63]), t64};
            qa.push_back(e16); qb.push_back(e16); qc.push_back(e64);
         end else begin
            sw_valid = 1'b0;
         end
         step();
         if (ov_a) begin
            checks++; e16 = (qa.size() != 0) ? qa.pop_front() : 18'h3FFFF;
            if ({of_a, bo_a, d_a} !== e16) begin errors++; $display("FAIL sweep16_4 got %b/%b/%h exp %h", of_a, bo_a, d_a, e16); end
         end
         if (ov_b) begin
            checks++; e16 = (qb.size() != 0) ? qb.pop_front() : 18'h3FFFF;
            if ({of_b, bo_b, d_b} !== e16) begin errors++; $display("FAIL sweep16_16 got %b/%b/%h exp %h", of_b, bo_b, d_b, e16); end
         end
         if (ov_c) begin
            checks++; e64 = (qc.size() != 0) ? qc.pop_front() : {66{1'b1}};
            if ({of_c, bo_c, d_c} !== e64) begin errors++; $display("FAIL sweep64_8 got %b/%b/%h exp %h", of_c, bo_c, d_c, e64); end
         end
      end
      checks++; if (qa.size() + qb.size() + qc.size() !== 0) begin errors++; $display("FAIL sweep_leftover got %0d/%0d/%0d exp 0", qa.size(), qb.size(), qc.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_underflow();
      test_ssat();
      test_back_to_back();
      test_reset_mid();
      test_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
